// File: rtl/puf_pkg.sv
// Shared constants, FSM state encoding and LFSR step function for the
// arbiter-PUF challenge/response sequencer.
package puf_pkg;

    localparam int         C_LENGTH_DEF = 8;
    localparam int         N_EVAL_DEF   = 5;
    localparam int         SETTLE_DEF   = 3;
    localparam logic [7:0] LFSR_TAP     = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_SAMPLE,
        ST_VOTE,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    // Galois form: shift right, fold the tap in when a one falls out.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAP) : (v >> 1);
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Seeded challenge LFSR with a separately captured challenge register, so the
// PUF challenge bus only moves when the sequencer asks for a new challenge.
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int C_LENGTH = C_LENGTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [C_LENGTH-1:0] seed_i,
    input  logic                step_i,
    input  logic                capture_i,
    output logic [C_LENGTH-1:0] challenge_o
);

    logic [C_LENGTH-1:0] lfsr_q, lfsr_d;
    logic [C_LENGTH-1:0] chal_q;

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? C_LENGTH'(1) : seed_i;
        end else if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= C_LENGTH'(1);
            chal_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            if (capture_i) begin
                chal_q <= lfsr_d;
            end
        end
    end

    assign challenge_o = chal_q;

endmodule

// File: rtl/puf_crp_sequencer.sv
// Arbiter-PUF challenge/response sequencer: launch, settle, sample, majority
// vote, byte packing and valid/ready output. Optional feature: PUF_STABILITY_EN.
module puf_crp_sequencer
    import puf_pkg::*;
#(
    parameter int C_LENGTH = C_LENGTH_DEF,
    parameter int N_EVAL   = N_EVAL_DEF,
    parameter int SETTLE   = SETTLE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [C_LENGTH-1:0] i_seed,
    input  logic [7:0]          i_num_bytes,
    output logic [C_LENGTH-1:0] o_challenge,
    output logic                o_pulse,
    input  logic                i_response,
    output logic [7:0]          o_data,
    output logic [7:0]          o_mask,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_done
);

    localparam int CW = $clog2(N_EVAL + 1);
    localparam int WW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] EVAL_LAST = CW'(N_EVAL - 1);
    localparam logic [CW-1:0] ONES_ALL  = CW'(N_EVAL);
    localparam logic [CW-1:0] HALF      = CW'(N_EVAL / 2);

    if (C_LENGTH != 8) begin : g_bad_clen
        $error("puf_crp_sequencer: C_LENGTH must be 8");
    end
    if (N_EVAL < 1 || (N_EVAL % 2) == 0) begin : g_bad_neval
        $error("puf_crp_sequencer: N_EVAL must be odd and >= 1");
    end
    if (SETTLE < 3) begin : g_bad_settle
        $error("puf_crp_sequencer: SETTLE must be >= 3");
    end

    state_t          state_q, state_d;
    logic            sync1_q, resp_s_q;
    logic [CW-1:0]   ones_q, ones_d;
    logic [CW-1:0]   eval_q, eval_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [2:0]      bit_q, bit_d;
    logic [8:0]      bytes_q, bytes_d;
    logic [7:0]      data_q, data_d;
    logic            pulse_q, valid_q, busy_q, done_q;
    logic            lfsr_load, lfsr_step_en;

    puf_lfsr #(.C_LENGTH(C_LENGTH)) u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (lfsr_load),
        .seed_i      (i_seed),
        .step_i      (lfsr_step_en),
        .capture_i   (state_d == ST_LOAD),
        .challenge_o (o_challenge)
    );

    always_comb begin
        state_d      = state_q;
        ones_d       = ones_q;
        eval_d       = eval_q;
        wait_d       = wait_q;
        bit_d        = bit_q;
        bytes_d      = bytes_q;
        data_d       = data_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    lfsr_load = 1'b1;
                    bytes_d   = (i_num_bytes == 8'd0) ? 9'd256 : {1'b0, i_num_bytes};
                    bit_d     = 3'd0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ones_d  = '0;
                eval_d  = '0;
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                wait_d  = WW'(SETTLE - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            ST_SAMPLE: begin
                ones_d  = ones_q + CW'(resp_s_q);
                eval_d  = eval_q + CW'(1);
                state_d = (eval_q == EVAL_LAST) ? ST_VOTE : ST_LAUNCH;
            end
            ST_VOTE: begin
                data_d       = {data_q[6:0], (ones_q > HALF)};
                lfsr_step_en = 1'b1;
                bit_d        = bit_q + 3'd1;
                state_d      = (bit_q == 3'd7) ? ST_OUTPUT : ST_LOAD;
            end
            ST_OUTPUT: begin
                if (i_ready) begin
                    bytes_d = bytes_q - 9'd1;
                    state_d = (bytes_q == 9'd1) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sync1_q  <= 1'b0;
            resp_s_q <= 1'b0;
            ones_q   <= '0;
            eval_q   <= '0;
            wait_q   <= '0;
            bit_q    <= 3'd0;
            bytes_q  <= 9'd0;
            data_q   <= 8'd0;
            pulse_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= i_response;
            resp_s_q <= sync1_q;
            ones_q   <= ones_d;
            eval_q   <= eval_d;
            wait_q   <= wait_d;
            bit_q    <= bit_d;
            bytes_q  <= bytes_d;
            data_q   <= data_d;
            pulse_q  <= (state_d == ST_LAUNCH);
            valid_q  <= (state_d == ST_OUTPUT);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

`ifdef PUF_STABILITY_EN
    logic [7:0] mask_q, mask_d;

    // Non-unanimous votes mark the bit as unstable, packed alongside o_data.
    always_comb begin
        mask_d = mask_q;
        if (state_q == ST_VOTE) begin
            mask_d = {mask_q[6:0], (ones_q != '0) && (ones_q != ONES_ALL)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 8'd0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign o_mask = mask_q;
`else
    assign o_mask = 8'd0;
`endif

    assign o_pulse = pulse_q;
    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed bench for puf_crp_sequencer: table-driven runs against a behavioural
// PUF, plus backpressure, reset-in-flight and reset-value sequences.
module tb_puf_crp_sequencer;

    localparam int NEV = 5;
    localparam int M_ALL1     = 0;
    localparam int M_NOISY_B8 = 1;
    localparam int M_ALL0     = 2;
    localparam int M_LSB      = 3;
    localparam int M_NOISY_E1 = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_seed;
    logic [7:0] i_num_bytes;
    logic [7:0] o_challenge;
    logic       o_pulse;
    logic       i_response;
    logic [7:0] o_data;
    logic [7:0] o_mask;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    puf_crp_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_seed      (i_seed),
        .i_num_bytes (i_num_bytes),
        .o_challenge (o_challenge),
        .o_pulse     (o_pulse),
        .i_response  (i_response),
        .o_data      (o_data),
        .o_mask      (o_mask),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        logic [7:0] seed;
        int         nb;
        int         mode;
        logic [7:0] first_chal;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;
        logic [7:0] exp_m0;
        logic [7:0] exp_m1;
        bit         poke;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] v);
        logic [7:0] s;
        s = {1'b0, v[7:1]};
        if (v[0]) s = s ^ 8'hB8;
        return s;
    endfunction

    function automatic logic resp_of(input int mode, input logic [7:0] ch, input int ev);
        case (mode)
            M_ALL1:     return 1'b1;
            M_NOISY_B8: return (ch == 8'hB8) ? (ev < 2) : 1'b1;
            M_ALL0:     return 1'b0;
            M_LSB:      return ch[0];
            M_NOISY_E1: return (ch == 8'hE1) ? (ev < 3) : 1'b0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] exp_mask(input logic [7:0] m);
`ifdef PUF_STABILITY_EN
        return m;
`else
        return (m & 8'h00);
`endif
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int         k = 1;
        int         pulses = 0;
        int         nbytes = 0;
        int         valid_cycles = 0;
        int         first_valid_k = -1;
        int         chal_errs = 0;
        int         ev;
        bit         finished = 1'b0;
        logic [7:0] chal_exp;

        @(negedge clk);
        i_seed      = v.seed;
        i_num_bytes = 8'(v.nb);
        i_ready     = 1'b1;
        i_start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start     = 1'b0;
        i_seed      = 8'hA5;
        i_num_bytes = 8'h07;
        chal_exp    = v.first_chal;
        check({tag, "_busy_start"}, 32'(o_busy), 32'd1);
        check({tag, "_first_chal"}, 32'(o_challenge), 32'(v.first_chal));

        while (!finished && k < 3000) begin
            if (o_pulse) begin
                ev = pulses % NEV;
                if (ev == 0 && pulses > 0) chal_exp = ref_step(chal_exp);
                if (o_challenge !== chal_exp) chal_errs++;
                i_response = resp_of(v.mode, chal_exp, ev);
                pulses++;
            end
            if (o_valid) begin
                valid_cycles++;
                if (nbytes == 0) first_valid_k = k;
                check({tag, "_data"}, 32'(o_data), 32'((nbytes == 0) ? v.exp_d0 : v.exp_d1));
                check({tag, "_mask"}, 32'(o_mask),
                      32'(exp_mask((nbytes == 0) ? v.exp_m0 : v.exp_m1)));
                nbytes++;
            end
            if (o_done) begin
                check({tag, "_busy_at_done"}, 32'(o_busy), 32'd1);
                finished = 1'b1;
            end
            if (v.poke && k == 40) begin
                i_start     = 1'b1;
                i_seed      = 8'h55;
                i_num_bytes = 8'h03;
            end
            if (v.poke && k == 41) i_start = 1'b0;
            @(negedge clk);
            k++;
        end

        check({tag, "_timeout"}, 32'(finished), 32'd1);
        check({tag, "_pulses"}, 32'(pulses), 32'(v.nb * 8 * NEV));
        check({tag, "_chal_seq_errs"}, 32'(chal_errs), 32'd0);
        check({tag, "_bytes"}, 32'(valid_cycles), 32'(v.nb));
        check({tag, "_first_valid_cycle"}, 32'(first_valid_k), 32'd217);
        check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
        check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        vec_t       rv;
        int         n;
        int         bad_valid, bad_data, bad_pulse, bad_chal;
        bit         got;

        vecs[0] = '{8'h01, 1, M_ALL1,     8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{8'h01, 1, M_NOISY_B8, 8'h01, 8'hBF, 8'h00, 8'h40, 8'h00, 1'b0};
        vecs[2] = '{8'h00, 2, M_LSB,      8'h01, 8'h8E, 8'h25, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'h01, 1, M_ALL0,     8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hB8, 1, M_LSB,      8'hB8, 8'h1C, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'h17, 1, M_NOISY_E1, 8'h17, 8'h20, 8'h00, 8'h20, 8'h00, 1'b0};

        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_seed      = 8'h00;
        i_num_bytes = 8'h00;
        i_response  = 1'b0;
        i_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_challenge", 32'(o_challenge), 32'd0);
        check("rst_pulse",     32'(o_pulse),     32'd0);
        check("rst_data",      32'(o_data),      32'd0);
        check("rst_mask",      32'(o_mask),      32'd0);
        check("rst_valid",     32'(o_valid),     32'd0);
        check("rst_busy",      32'(o_busy),      32'd0);
        check("rst_done",      32'(o_done),      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_challenge", 32'(o_challenge), 32'd0);
        check("idle_busy",      32'(o_busy),      32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold i_ready low for 100 cycles in OUTPUT.
        i_response  = 1'b1;
        i_ready     = 1'b0;
        i_seed      = 8'h01;
        i_num_bytes = 8'd1;
        i_start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        got = 1'b0;
        for (n = 0; n < 400 && !got; n++) begin
            if (o_valid) got = 1'b1;
            else @(negedge clk);
        end
        check("bp_valid_arrives", 32'(got), 32'd1);
        bad_valid = 0; bad_data = 0; bad_pulse = 0; bad_chal = 0;
        for (int c = 0; c < 100; c++) begin
            if (o_valid !== 1'b1) bad_valid++;
            if (o_data !== 8'hFF) bad_data++;
            if (o_pulse !== 1'b0) bad_pulse++;
            if (o_challenge !== 8'hC8) bad_chal++;
            @(negedge clk);
        end
        check("bp_valid_held",  32'(bad_valid), 32'd0);
        check("bp_data_stable", 32'(bad_data),  32'd0);
        check("bp_no_pulse",    32'(bad_pulse), 32'd0);
        check("bp_chal_stable", 32'(bad_chal),  32'd0);
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_xfer_valid_drop", 32'(o_valid), 32'd0);
        check("bp_xfer_done",       32'(o_done),  32'd1);
        @(negedge clk);
        check("bp_done_once", 32'(o_done), 32'd0);
        check("bp_busy_off",  32'(o_busy), 32'd0);

        // Reset while waiting on the first evaluation of byte 1.
        i_seed      = 8'h01;
        i_num_bytes = 8'd1;
        i_start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        got = 1'b0;
        for (n = 0; n < 50 && !got; n++) begin
            if (o_pulse) got = 1'b1;
            else @(negedge clk);
        end
        check("rr_pulse_seen", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rr_busy",      32'(o_busy),      32'd0);
        check("rr_pulse",     32'(o_pulse),     32'd0);
        check("rr_valid",     32'(o_valid),     32'd0);
        check("rr_challenge", 32'(o_challenge), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv = '{8'h2E, 1, M_ALL1, 8'h2E, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        run_vec(rv, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_crp_sequencer.md
# puf_crp_sequencer

Challenge-response driver for the arbiter PUF. It sequences challenges from a seeded LFSR onto the PUF challenge bus and fires a launch pulse into the delay line. It samples and majority-votes the PUF response bit, packs the voted bits into bytes, and hands the bytes out on a valid/ready stream. It is the initiator/reader for the arbiter PUF and sits between the top-level IO wrapper and the PUF instance.

## Interface
- C_LENGTH, 8: challenge width. Only 8 is supported; any other value is an elaboration error.
- N_EVAL, 5: evaluations per challenge. Must be odd and ≥1; an even value is an elaboration error.
- SETTLE, 3: cycles between the launch edge and sampling. Must be ≥3, which covers the delay line plus the 2-flop synchronizer.

Ports:
- clk  in  1  system clock. This is also the timing reference for o_pulse.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle request to begin a run. Ignored while o_busy=1.
- i_seed  in  C_LENGTH  LFSR seed, sampled on i_start.
- i_num_bytes  in  8  bytes to produce, sampled on i_start. 0 means 256.
- o_challenge  out  C_LENGTH  challenge driven to the PUF.
- o_pulse  out  1  launch pulse, driven to the PUF ipulse input.
- i_response  in  1  PUF response, asynchronous to clk.
- o_data  out  8  packed response byte.
- o_mask  out  8  unstable-bit flags (see Configuration).
- o_valid  out  1  o_data/o_mask are valid.
- i_ready  in  1  downstream accepts the byte.
- o_busy  out  1  a run is in progress.
- o_done  out  1  one-cycle pulse after the last byte is transferred.

## Operation
- i_response passes through a 2-flop synchronizer (resp_s) before any use.
- FSM states: IDLE, LOAD, LAUNCH, WAIT, SAMPLE, VOTE, OUTPUT, DONE.
- IDLE:
  - On i_start, the LFSR loads i_seed; a seed of 0x00 is replaced by 0x01.
  - The byte counter loads i_num_bytes.
  - Go to LOAD.
- LOAD:
  - o_challenge takes the LFSR value; o_pulse=0.
  - The ones counter and evaluation counter clear.
  - Go to LAUNCH.
- LAUNCH: o_pulse=1 for exactly one cycle, then go to WAIT.
- WAIT: o_pulse=0; stay for SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - ones += resp_s; the evaluation counter increments.
  - If the evaluation counter < N_EVAL, go to LAUNCH; otherwise go to VOTE.
- VOTE:
  - bit = (ones > N_EVAL/2). Shift it into the byte shift register MSB-first: the first bit lands in o_data[7].
  - The LFSR advances one step.
  - After the 8th bit, go to OUTPUT; otherwise go to LOAD.
- LFSR: 8-bit Galois, right shift, XOR with TAP=0xB8 when the shifted-out bit is 1. Sequence from 0x01 is 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
- OUTPUT:
  - o_valid=1. o_data and o_mask are held stable until i_ready=1.
  - On transfer, the byte counter decrements. If it reaches 0, go to DONE; otherwise go to LOAD.
- DONE: o_done=1 for one cycle, then go to IDLE.
- o_challenge is constant from LOAD through VOTE, so it never changes while o_pulse=1 or between launch and sample.
- o_pulse is registered and glitch-free.

## Timing
- Reset values:
  - State IDLE.
  - o_challenge, o_pulse, o_data, o_mask, o_valid, o_busy, o_done all 0.
  - LFSR 0x01.
- o_busy is 1 from the cycle after i_start until the DONE cycle, inclusive.
- Cycles per bit = 2 + N_EVAL×(SETTLE+2). With defaults this is 27.
- First o_valid asserts 8×27 = 216 cycles after the i_start cycle plus one cycle (defaults).
- A transfer occurs on any cycle with o_valid=1 and i_ready=1, including the first cycle of o_valid.
- i_ready low holds the FSM in OUTPUT: no launches and no challenge change.
- i_start during a run is ignored and does not change the sampled parameters.
- rst_n asserting in any state returns to the reset values immediately. The partial byte is discarded.
- The ones counter is $clog2(N_EVAL+1) bits wide and cannot overflow.
- The byte counter is 9 bits wide so that the value 256 is representable.

## Configuration
- PUF_STABILITY_EN defined:
  - A bit is flagged unstable when its votes were not unanimous (ones ≠ 0 and ones ≠ N_EVAL).
  - The flag shifts into o_mask in lockstep with o_data.
- PUF_STABILITY_EN undefined: o_mask is tied to 0 and no flag logic is built.

## Structure
- Shared package puf_pkg holds:
  - C_LENGTH default.
  - LFSR TAP constant (0xB8).
  - FSM state enum.
  - Default N_EVAL and SETTLE values.
- One sub-module, puf_lfsr: load/seed-fix/step, with the challenge output.
- The synchronizer, FSM, counters and packer live in the top.

## Test plan
- Reset: hold rst_n=0 -> all outputs 0. Release -> state IDLE, o_challenge=0x00.
- PUF model response=1 always, seed 0x01, num_bytes=1:
  - Challenges observed: 0x01, 0xB8, 0x5C, ...
  - o_data=0xFF and o_mask=0x00.
  - o_done pulses once after the transfer.
- Noisy model: the response flips on 2 of 5 evaluations, only for challenge 0xB8 (true value 0) -> o_data bit 6 = 0.
  - With PUF_STABILITY_EN: o_mask=0x40.
  - Without it: o_mask=0x00.
- Backpressure: i_ready=0 for 100 cycles at OUTPUT.
  - o_valid stays 1; o_data is stable.
  - o_pulse stays 0; o_challenge is unchanged.
  - On i_ready=1, the transfer happens in the same cycle.
- Seed 0x00, num_bytes=2 -> first challenge 0x01. Two bytes are delivered, then o_done and o_busy=0.
- Reset mid-run: pull rst_n low during WAIT of byte 1 -> o_busy=0, o_pulse=0, o_valid=0 immediately. A new i_start runs cleanly from its seed.
